// File: rtl/servo_capture.sv
// Servo-pulse decoder: measures the high time of an RC/servo PWM input and returns the 8-bit position code.
// Optional SERVO_CAPTURE_GLITCH_EN adds a 3-cycle stability filter after the synchronizer.
module servo_capture #(
  parameter int OFFSET  = 6000,
  parameter int TICK    = 94,
  parameter int MAX_W   = 36000,
  parameter int TIMEOUT = 300000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       servo_in,
  output logic [7:0] pos,
  output logic       valid,
  output logic       err,
  output logic       lost
);

  localparam int HC_W = $clog2(MAX_W + 1);
  localparam int PRE_W = $clog2(TICK);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [HC_W-1:0]  OFF_C     = HC_W'(OFFSET);
  localparam logic [HC_W-1:0]  MAX_C     = HC_W'(MAX_W);
  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK - 1);
  localparam logic [WD_W-1:0]  TO_C      = WD_W'(TIMEOUT);

  localparam logic [2:0] ARM   = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] OFFS  = 3'd2;
  localparam logic [2:0] UNITS = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             s_q, s_d;
  logic             s_prev_q, s_prev_d;
  logic             rise;
  logic [2:0]       state_q, state_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       units_q, units_d;
  logic [7:0]       pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             lost_q, lost_d;
`ifdef SERVO_CAPTURE_GLITCH_EN
  logic [2:0]       hist_q, hist_d;
`endif

  always_comb begin
    sync1_d = servo_in;
    sync2_d = sync1_q;
`ifdef SERVO_CAPTURE_GLITCH_EN
    hist_d = {hist_q[1:0], sync2_q};
    s_d = s_q;
    if (hist_q == 3'b111) begin
      s_d = 1'b1;
    end else if (hist_q == 3'b000) begin
      s_d = 1'b0;
    end
`else
    s_d = sync2_q;
`endif
    s_prev_d = s_q;
    rise = s_q & ~s_prev_q;
  end

  // Cycle counter holds the number of high cycles seen so far, including the current one.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    pre_d   = pre_q;
    units_d = units_q;
    pos_d   = pos_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ARM: begin
        if (!s_q) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          hc_d    = HC_W'(1);
          state_d = OFFS;
        end
      end
      OFFS: begin
        if (!s_q) begin
          pos_d   = 8'd0;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (hc_q == MAX_C) begin
          err_d   = 1'b1;
          state_d = OVER;
        end else begin
          hc_d = hc_q + HC_W'(1);
          if (hc_d == OFF_C) begin
            pre_d   = '0;
            units_d = 8'd0;
            state_d = UNITS;
          end
        end
      end
      UNITS: begin
        if (!s_q) begin
          pos_d   = units_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (hc_q == MAX_C) begin
          err_d   = 1'b1;
          state_d = OVER;
        end else begin
          hc_d = hc_q + HC_W'(1);
          if (pre_q == TICK_LAST) begin
            pre_d = '0;
            if (units_q != 8'hFF) units_d = units_q + 8'd1;
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
      OVER: begin
        if (!s_q) state_d = IDLE;
      end
      default: state_d = ARM;
    endcase
  end

  // Watchdog saturates at TIMEOUT; lost is sticky from reset until the first good pulse.
  always_comb begin
    if (valid_q) begin
      wd_d   = '0;
      lost_d = 1'b0;
    end else begin
      wd_d   = (wd_q == TO_C) ? wd_q : wd_q + WD_W'(1);
      lost_d = lost_q | (wd_d == TO_C);
    end
  end

  // Input pipeline resets high so a line already high at reset looks like a pulse in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
`ifdef SERVO_CAPTURE_GLITCH_EN
      hist_q   <= 3'b111;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      s_q      <= s_d;
      s_prev_q <= s_prev_d;
`ifdef SERVO_CAPTURE_GLITCH_EN
      hist_q   <= hist_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARM;
      hc_q    <= '0;
      pre_q   <= '0;
      units_q <= 8'd0;
      pos_q   <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      pre_q   <= pre_d;
      units_q <= units_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      lost_q  <= lost_d;
    end
  end

  assign pos   = pos_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_servo_capture.sv
// Directed bench for servo_capture using scaled timing parameters (OFFSET 600, TICK 9, MAX_W 3600, TIMEOUT 5000).
// Define SERVO_CAPTURE_GLITCH_EN for both bench and RTL to exercise the filtered build.
module tb_servo_capture;

  localparam int OFFSET  = 600;
  localparam int TICK    = 9;
  localparam int MAX_W   = 3600;
  localparam int TIMEOUT = 5000;
`ifdef SERVO_CAPTURE_GLITCH_EN
  localparam int LAT    = 6;
  localparam int GAP    = 3;
  localparam int SPIKES = 0;
`else
  localparam int LAT    = 3;
  localparam int GAP    = 1;
  localparam int SPIKES = 5;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       servo_in = 1'b0;
  logic [7:0] pos;
  logic       valid;
  logic       err;
  logic       lost;

  int vectors = 0;
  int miscompares = 0;
  int obs_vcnt, obs_vk, obs_vpos, obs_ecnt, obs_ek, obs_vlost;
  int tot_valid = 0;
  int tot_err = 0;
  int base_v, base_e;
  logic [7:0] last_pos = 8'd0;
  logic [7:0] prev_pos = 8'd0;

  servo_capture #(
    .OFFSET (OFFSET),
    .TICK   (TICK),
    .MAX_W  (MAX_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .servo_in(servo_in),
    .pos     (pos),
    .valid   (valid),
    .err     (err),
    .lost    (lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      tot_valid++;
      prev_pos = last_pos;
      last_pos = pos;
    end
    if (err === 1'b1) tot_err++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Pin high for w clock samples, then low for tail samples; index k counts edges since the first high sample.
  task automatic applyStimulus(input int w, input int tail);
    obs_vcnt = 0; obs_vk = 0; obs_vpos = -1; obs_ecnt = 0; obs_ek = 0; obs_vlost = -1;
    @(negedge clk);
    servo_in = 1'b1;
    for (int k = 1; k <= w + tail; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        obs_vcnt++;
        obs_vk = k;
        obs_vpos = pos;
        obs_vlost = lost;
      end
      if (err === 1'b1) begin
        obs_ecnt++;
        obs_ek = k;
      end
      if (k == w) servo_in = 1'b0;
    end
  endtask

  task automatic checkPulse(input string tag, input int w, input int exp_pos);
    applyStimulus(w, LAT + 6);
    checkOutput({tag, ".valid_count"}, obs_vcnt, 1);
    checkOutput({tag, ".valid_cycle"}, obs_vk, w + LAT + 1);
    checkOutput({tag, ".pos"}, obs_vpos, exp_pos);
    checkOutput({tag, ".err_count"}, obs_ecnt, 0);
  endtask

  task automatic checkOver(input string tag, input int w, input int held_pos);
    applyStimulus(w, LAT + 6);
    checkOutput({tag, ".err_count"}, obs_ecnt, 1);
    checkOutput({tag, ".err_cycle"}, obs_ek, MAX_W + 1 + LAT);
    checkOutput({tag, ".valid_count"}, obs_vcnt, 0);
    checkOutput({tag, ".pos_held"}, pos, held_pos);
  endtask

  initial begin
    rstn = 1'b0;
    servo_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.pos", pos, 0);
    checkOutput("reset.valid", valid, 0);
    checkOutput("reset.err", err, 0);
    checkOutput("reset.lost", lost, 1);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("idle.lost", lost, 1);

    checkPulse("w1747", 1747, 127);
    checkOutput("w1747.lost_at_valid", obs_vlost, 1);
    checkOutput("w1747.lost_after", lost, 0);

    checkPulse("w599", 599, 0);
    checkPulse("w600", 600, 0);
    checkPulse("w608", 608, 0);
    checkPulse("w609", 609, 1);
    checkPulse("w2894", 2894, 254);
    checkPulse("w2895", 2895, 255);
    checkPulse("w3400", 3400, 255);
    checkPulse("w100", 100, 0);
    checkPulse("w3600", 3600, 255);
    checkPulse("w1200", 1200, 66);

    checkOver("w4000", 4000, 66);
    checkOver("w3601", 3601, 66);
    checkPulse("w1300", 1300, 77);

    // Two pulses separated by the shortest low gap the input path passes through.
    base_v = tot_valid;
    base_e = tot_err;
    @(negedge clk);
    servo_in = 1'b1;
    repeat (700) @(negedge clk);
    servo_in = 1'b0;
    repeat (GAP) @(negedge clk);
    servo_in = 1'b1;
    repeat (1747) @(negedge clk);
    servo_in = 1'b0;
    repeat (LAT + 6) @(negedge clk);
    checkOutput("b2b.valid_count", tot_valid - base_v, 2);
    checkOutput("b2b.first_pos", prev_pos, 11);
    checkOutput("b2b.second_pos", last_pos, 127);
    checkOutput("b2b.err_count", tot_err - base_e, 0);

    // Valid occurred 5 cycles before checkPulse returns.
    checkPulse("wd", 1747, 127);
    base_v = tot_valid;
    repeat (TIMEOUT - 5) @(negedge clk);
    checkOutput("wd.lost_before", lost, 0);
    @(negedge clk);
    checkOutput("wd.lost_rise", lost, 1);
    checkOutput("wd.pos_hold", pos, 127);
    checkOutput("wd.no_valid", tot_valid - base_v, 0);

    @(negedge clk);
    rstn = 1'b0;
    servo_in = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    base_v = tot_valid;
    base_e = tot_err;
    repeat (4000) @(negedge clk);
    servo_in = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("hiatreset.valid", tot_valid - base_v, 0);
    checkOutput("hiatreset.err", tot_err - base_e, 0);
    checkPulse("after_hi", 1747, 127);

    checkOutput("midrst.lost_pre", lost, 0);
    @(negedge clk);
    servo_in = 1'b1;
    repeat (1000) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midrst.pos", pos, 0);
    checkOutput("midrst.valid", valid, 0);
    checkOutput("midrst.err", err, 0);
    checkOutput("midrst.lost", lost, 1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    base_v = tot_valid;
    base_e = tot_err;
    repeat (500) @(negedge clk);
    servo_in = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midrst.discard_valid", tot_valid - base_v, 0);
    checkOutput("midrst.discard_err", tot_err - base_e, 0);

    base_v = tot_valid;
    base_e = tot_err;
    for (int i = 0; i < 5; i++) begin
      servo_in = 1'b1;
      repeat (2) @(negedge clk);
      servo_in = 1'b0;
      repeat (12) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checkOutput("spikes.valid", tot_valid - base_v, SPIKES);
    checkOutput("spikes.err", tot_err - base_e, 0);
    checkPulse("final", 1747, 127);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/servo_capture.md
# servo_capture

Servo-pulse decoder: the receive counterpart of the servo pulse generator. Measures the high time of an incoming RC/servo PWM signal and converts it back to the same 8-bit position code the generator accepts, with a one-cycle strobe per good pulse. Sits behind an input pin, for example to read an RC receiver channel or to loop back a servo output for self-test, and feeds position-consuming logic such as a servo unit or a ROM/log writer.

## Interface
- `OFFSET`, 6000: cycles of high time that map to position 0 (0.5 ms at 12 MHz).
- `TICK`, 94: cycles per position step (about 2 ms / 255 at 12 MHz); must be ≥ 2.
- `MAX_W`, 36000: maximum legal high time in cycles (3 ms); must be > `OFFSET`.
- `TIMEOUT`, 300000: cycles without a good pulse before `lost` asserts (25 ms).
- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `servo_in` in 1: asynchronous servo PWM input, active high.
- `pos` out 8: last decoded position; holds its value between pulses.
- `valid` out 1: one-cycle strobe when `pos` updates.
- `err` out 1: one-cycle strobe when a pulse is rejected.
- `lost` out 1: level; high while no good pulse has arrived within `TIMEOUT`.

## Operation
- Input path: 2-FF synchronizer, plus one delay register for edge detection. The result is `s`; a rise means `s`=1 and its previous value was 0.
- W is the number of consecutive cycles `s` is high. Decoded position = 0 if W < `OFFSET`, otherwise min(255, floor((W−`OFFSET`)/`TICK`)).
- State machine:
  - ARM (reset state): wait for `s`=0, then go to IDLE. A line that is already high at reset is never measured.
  - IDLE: on a rise, clear the cycle counter and go to OFFS.
  - OFFS: count cycles while `s`=1.
    - When the count reaches `OFFSET`, clear the prescaler and unit counter and go to UNITS.
    - If `s` falls first: position 0, `valid`, return to IDLE.
  - UNITS: prescaler counts 0..`TICK`−1. On wrap, the unit counter increments, saturating at 255.
    - If `s` falls: `pos` takes the unit count, `valid` pulses, return to IDLE.
  - OVER: entered from OFFS or UNITS when `s` is still high after `MAX_W` cycles. `err` pulses once on entry. Wait for `s`=0, then go to IDLE. `pos` does not change.
- The total high-time counter runs in OFFS and UNITS and is sized for `MAX_W`.
- Watchdog counter:
  - Cleared on every `valid`; counts otherwise, saturating.
  - `lost` is 1 while the count ≥ `TIMEOUT`, and 0 from the cycle after `valid` onward.
  - `err` does not clear the watchdog.
- `valid` and `err` are mutually exclusive and never high in the same cycle.

## Timing
- Reset values: `pos`=0, `valid`=0, `err`=0, `lost`=1, state ARM, all counters 0.
- `servo_in` edges reach the edge detector 2 cycles after the pin is sampled.
- `valid` is registered. It asserts 3 clk cycles after the first rising edge of `clk` that samples `servo_in` low, and is high for exactly 1 cycle. `pos` changes in that same cycle.
- `err` asserts 3 cycles after the `clk` edge on which the pin's high time reaches `MAX_W`+1 samples, and lasts 1 cycle.
- Back-to-back pulses: a rise seen in the cycle right after a fall is accepted. There is no minimum low time.
- Asserting `rstn` mid-pulse aborts the measurement immediately. After release the block starts in ARM, so the pulse in progress is discarded.
- Pulse period is not checked; only high time and the watchdog are.

## Configuration
- `SERVO_CAPTURE_GLITCH_EN` defined: a 3-cycle majority/stability filter follows the synchronizer. `s` changes only after the synchronized input has held a new value for 3 consecutive cycles.
  - High pulses shorter than 3 cycles are ignored.
  - All input-to-output latencies grow by 3 cycles.
  - W is unchanged for clean pulses.
- Not defined: no filter, and latencies are exactly as stated above.

## Test plan
- Reset, `servo_in` low, 18000-cycle (1.5 ms) high pulse → one `valid`, `pos`=127, `err`=0, `lost` falls to 0 after `valid`.
- High pulses of 6000, 29970, 34000 cycles → `pos`=0, 255, 255 (saturation). A 100-cycle pulse → `pos`=0 with `valid`.
- 40000-cycle high pulse → `err` once at high-count 36001 + 3 cycles, no `valid`, `pos` unchanged. The next 12000-cycle pulse → `pos`=63.
- `servo_in` held high through reset release, then falls after 20000 cycles → no `valid`/`err`. The following 18000-cycle pulse → `pos`=127.
- After a good pulse, input idle for 300000 cycles → `lost` rises, `pos` holds. `rstn` asserted mid-pulse → outputs return to reset values immediately.
- With `SERVO_CAPTURE_GLITCH_EN`: 2-cycle spikes → no `valid`/`err`. An 18000-cycle pulse → `pos`=127 with `valid` 6 cycles after the fall.
